inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: requests 4-word groups and queues {inst, pc} entries for decode.
// Optional macro FETCH_ALIGN_EN: fetch 16-byte aligned groups and drop words below fetch_pc.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        InstMem_Read,
    output logic [31:0] InstMem_Address,
    input  logic        InstMem_Ready,
    input  logic [31:0] inst1_in,
    input  logic [31:0] inst2_in,
    input  logic [31:0] inst3_in,
    input  logic [31:0] inst4_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(BUF_DEPTH - 4);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_mem_read;
    logic [31:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [31:0]      r_buf_inst [BUF_DEPTH];
    logic [31:0]      r_buf_pc   [BUF_DEPTH];

    logic [31:0]      w_group [4];
    logic [PTR_W-1:0] w_slot  [4];
    logic [31:0]      w_base;
    logic [1:0]       w_skip;
    logic [2:0]       w_grp_n;
    logic [2:0]       w_push_n;
    logic [31:0]      w_pc_next;
    logic             w_accept;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_push;
    logic [CNT_W-1:0] w_count_next;

`ifdef FETCH_ALIGN_EN
    assign w_base = r_fetch_pc & 32'hFFFF_FFF0;
    assign w_skip = r_fetch_pc[3:2];
`else
    assign w_base = r_fetch_pc;
    assign w_skip = 2'd0;
`endif

    assign w_group[0] = inst1_in;
    assign w_group[1] = inst2_in;
    assign w_group[2] = inst3_in;
    assign w_group[3] = inst4_in;

    assign w_grp_n   = 3'd4 - 3'(w_skip);
    assign w_pc_next = w_base + 32'd16;

    // A redirect in the same cycle discards the returning group.
    assign w_accept     = (r_state == REQ) && InstMem_Ready && !redirect_valid;
    assign w_pop        = (r_count != '0) && dec_ready;
    assign w_push_n     = w_accept ? w_grp_n : 3'd0;
    assign w_count_push = r_count + CNT_W'(w_push_n);
    assign w_count_next = w_count_push - CNT_W'(w_pop);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_slot[k] = r_tail + PTR_W'(k) - PTR_W'(w_skip);
        end
    end

    // Buffer storage: only words at or above the skip offset are written, packed from the tail.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_accept && (2'(k) >= w_skip)) begin
                r_buf_inst[w_slot[k]] <= w_group[k];
                r_buf_pc[w_slot[k]]   <= w_base + 32'(4 * k);
            end
        end
    end

    // Fetch FSM and buffer bookkeeping; free-space decisions never credit a same-cycle pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_mem_read <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else if (redirect_valid) begin
            r_state    <= IDLE;
            r_mem_read <= 1'b0;
            r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_count <= w_count_next;
            r_head  <= r_head + PTR_W'(w_pop);
            r_tail  <= r_tail + PTR_W'(w_push_n);
            case (r_state)
                IDLE: begin
                    if (r_count <= FILL_MAX) begin
                        r_state    <= REQ;
                        r_mem_read <= 1'b1;
                    end
                end
                REQ: begin
                    if (InstMem_Ready) begin
                        r_fetch_pc <= w_pc_next;
                        if (w_count_push > FILL_MAX) begin
                            r_state    <= IDLE;
                            r_mem_read <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_mem_read <= 1'b0;
                end
            endcase
        end
    end

    assign InstMem_Read    = r_mem_read;
    assign InstMem_Address = w_base;
    assign dec_valid       = (r_count != '0);
    assign dec_inst        = dec_valid ? r_buf_inst[r_head] : 32'd0;
    assign dec_pc          = dec_valid ? r_buf_pc[r_head] : 32'd0;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: the bench plays instruction memory and decode.
module tb_inst_fetch_ctrl;
    localparam int unsigned DEPTH   = 8;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] inst1, inst2, inst3, inst4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_ready;

    logic        w2_read;
    logic [31:0] w2_addr;
    logic        w2_valid;
    logic [31:0] w2_inst;
    logic [31:0] w2_pc;

    int          mem_lat = 0;
    int          lat_cnt;
    int          errors = 0;
    int          checks = 0;
    int          grp_cnt;
    logic [31:0] exp_pc;
    logic [63:0] sb[$];
    logic [31:0] acc[$];
    logic [31:0] acc2[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign inst1     = mem_word(mem_addr);
    assign inst2     = mem_word(mem_addr + 32'd4);
    assign inst3     = mem_word(mem_addr + 32'd8);
    assign inst4     = mem_word(mem_addr + 32'd12);
    assign mem_ready = mem_read && (lat_cnt >= mem_lat);

    inst_fetch_ctrl u_dut (
        .clk(clk), .rst(rst),
        .InstMem_Read(mem_read), .InstMem_Address(mem_addr), .InstMem_Ready(mem_ready),
        .inst1_in(inst1), .inst2_in(inst2), .inst3_in(inst3), .inst4_in(inst4),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready)
    );

    inst_fetch_ctrl #(.RESET_PC(WRAP_PC)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .InstMem_Read(w2_read), .InstMem_Address(w2_addr), .InstMem_Ready(w2_read),
        .inst1_in(32'd0), .inst2_in(32'd0), .inst3_in(32'd0), .inst4_in(32'd0),
        .redirect_valid(1'b0), .redirect_pc(32'd0),
        .dec_valid(w2_valid), .dec_inst(w2_inst), .dec_pc(w2_pc), .dec_ready(1'b1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_read", 32'(mem_read), 32'd0);
        chk("rst_valid", 32'(dec_valid), 32'd0);
        chk("rst_inst", dec_inst, 32'd0);
        chk("rst_pc", dec_pc, 32'd0);
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Memory latency: cycles the current request has been outstanding.
    always @(posedge clk or negedge rst) begin
        if (!rst) lat_cnt <= 0;
        else if (redirect_valid || !mem_read || mem_ready) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
    end

    // Monitor: pops/compares decode output, pushes expected entries when a group returns.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        logic [31:0] base;
        int          skip;
        if (!rst) begin
            sb.delete();
            acc.delete();
            grp_cnt = 0;
            exp_pc  = 32'h0000_0000;
        end else if (redirect_valid) begin
            sb.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            base = exp_pc;
            skip = 0;
`ifdef FETCH_ALIGN_EN
            base = {exp_pc[31:4], 4'b0000};
            skip = int'(exp_pc[3:2]);
`endif
            chk("mon_valid", 32'(dec_valid), 32'(sb.size() != 0));
            if (dec_valid && dec_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("mon_inst", dec_inst, e[63:32]);
                chk("mon_pc", dec_pc, e[31:0]);
            end else if (!dec_valid) begin
                chk("mon_empty", dec_inst | dec_pc, 32'd0);
            end
            if (mem_read) chk("mon_addr", mem_addr, base);
            if (mem_read && mem_ready) begin
                chk("mon_no_overflow", 32'(sb.size() + 4 - skip <= DEPTH), 32'd1);
                for (int k = skip; k < 4; k++) begin
                    sb.push_back({mem_word(base + 32'(4 * k)), base + 32'(4 * k)});
                end
                acc.push_back(mem_addr);
                grp_cnt++;
                exp_pc = base + 32'd16;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) acc2.delete();
        else if (w2_read) acc2.push_back(w2_addr);
    end

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        dec_ready      = 1'b1;
        mem_lat        = 0;

        // Free-running fetch with decode always ready.
        do_reset();
        tick();
        chk("first_read", 32'(mem_read), 32'd1);
        chk("first_addr", mem_addr, 32'h0000_0000);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("stream_valid", 32'(dec_valid), 32'd1);
            chk("stream_pc", dec_pc, 32'(4 * i));
            tick();
        end
        chk("acc_count", 32'(acc.size() >= 3), 32'd1);
        if (acc.size() >= 3) begin
            chk("acc0", acc[0], 32'h0000_0000);
            chk("acc1", acc[1], 32'h0000_0010);
            chk("acc2", acc[2], 32'h0000_0020);
        end

        // Decode stalled: buffer fills with two groups, refetch only after 4 pops.
        dec_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("stall_groups", 32'(grp_cnt), 32'd2);
        chk("stall_read", 32'(mem_read), 32'd0);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_read_low", 32'(mem_read), 32'd0);
        end
        tick();
        chk("drain_read_high", 32'(mem_read), 32'd1);
        repeat (6) tick();

        // Slow memory: address held until ready, one group per response.
        dec_ready = 1'b0;
        mem_lat   = 3;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("slow_read", 32'(mem_read), 32'd1);
            chk("slow_addr", mem_addr, 32'h0000_0000);
        end
        chk("slow_groups0", 32'(grp_cnt), 32'd0);
        tick();
        chk("slow_groups1", 32'(grp_cnt), 32'd1);
        chk("slow_addr2", mem_addr, 32'h0000_0010);
        repeat (3) tick();
        chk("slow_groups1b", 32'(grp_cnt), 32'd1);

        // Reset while a request is outstanding with data ready.
        mem_lat   = 0;
        dec_ready = 1'b1;
        do_reset();
        tick();
        chk("post_rst_read", 32'(mem_read), 32'd1);
        chk("post_rst_addr", mem_addr, 32'h0000_0000);

        // Redirect coincident with a memory response.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0104;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", 32'(dec_valid), 32'd0);
        chk("redir_read", 32'(mem_read), 32'd0);
        tick();
        chk("redir_req", 32'(mem_read), 32'd1);
`ifdef FETCH_ALIGN_EN
        chk("redir_addr", mem_addr, 32'h0000_0100);
`else
        chk("redir_addr", mem_addr, 32'h0000_0104);
`endif
        tick();
        chk("redir_head_valid", 32'(dec_valid), 32'd1);
        chk("redir_head_pc", dec_pc, 32'h0000_0104);
        chk("redir_head_inst", dec_inst, 32'h0000_0104 ^ 32'h5A5A_A5A5);
        repeat (12) tick();

        // PC wrap on the instance reset to 0xFFFF_FFF0.
        chk("wrap_count", 32'(acc2.size() >= 2), 32'd1);
        if (acc2.size() >= 2) begin
            chk("wrap_first", acc2[0], WRAP_PC);
            chk("wrap_second", acc2[1], 32'h0000_0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
